// File: rtl/reg_file_sb.sv
// Register file with integrated pending-write scoreboard: two combinational read
// ports, one write port, per-register busy bits and a running busy count.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  input  logic            SET_EN,
  input  logic [AW-1:0]   SET_ADDR,
  output logic [AW:0]     BUSY_CNT
);

  localparam logic          BYP     = (BYPASS != 0);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(NREGS - 1);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_nxt;
  logic             we_hit;
  logic             set_hit;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [XLEN-1:0]  stored1;
  logic [XLEN-1:0]  stored2;

  // Counter moves by at most one per edge; clamped so it can never wrap.
  function automatic logic [AW:0] cnt_update(input logic [AW:0] cnt,
                                             input logic inc, input logic dec);
    logic [AW:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end else if (dec && !inc) begin
      res = (cnt == '0) ? cnt : cnt - 1'b1;
    end
    return res;
  endfunction

  function automatic logic [XLEN-1:0] rd_sel(input logic [XLEN-1:0] stored,
                                             input logic [AW-1:0] addr);
    logic [XLEN-1:0] res;
    res = stored;
    if (rst || addr == '0) begin
      res = '0;
    end else if (BYP && WE3 && A3 == addr) begin
      res = WD3;
    end
    return res;
  endfunction

  function automatic logic busy_sel(input logic [AW-1:0] addr);
    logic res;
    res = busy_q[addr];
    if (rst || addr == '0) begin
      res = 1'b0;
    end else if (BYP && WE3 && A3 == addr) begin
      res = 1'b0;
    end
    return res;
  endfunction

  assign we_hit  = WE3 && (A3 != '0);
  assign set_hit = SET_EN && (SET_ADDR != '0);

  always_comb begin
    busy_nxt = busy_q;
    if (we_hit) begin
      busy_nxt[A3] = 1'b0;
    end
    // Set is applied after clear so a same-address collision leaves the bit set.
    if (set_hit) begin
      busy_nxt[SET_ADDR] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_inc = set_hit && !busy_q[SET_ADDR];
    cnt_dec = we_hit && busy_q[A3] && !(set_hit && SET_ADDR == A3);
    cnt_nxt = cnt_update(cnt_q, cnt_inc, cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we_hit) begin
      regs[A3] <= WD3;
    end
  end

  always_comb begin
    stored1 = regs[A1];
    stored2 = regs[A2];
    RD1     = rd_sel(stored1, A1);
    RD2     = rd_sel(stored2, A2);
    BUSY1   = busy_sel(A1);
    BUSY2   = busy_sel(A2);
  end

  assign BUSY_CNT = cnt_q;

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of each register, in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers; power of two, at least 2.
REQ-003 Parameter AW, default $clog2(NREGS): address width.
REQ-004 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 A1, A2  in  AW each  read addresses, ports 1 and 2.
REQ-008 RD1, RD2  out  XLEN each  combinational read data, ports 1 and 2.
REQ-009 BUSY1, BUSY2  out  1 each  pending-write flag for A1 and A2.
REQ-010 A3  in  AW  write address.
REQ-011 WD3  in  XLEN  write data.
REQ-012 WE3  in  1  write enable; a write also retires a pending-write mark.
REQ-013 SET_EN  in  1  issue strobe; marks register SET_ADDR as pending.
REQ-014 SET_ADDR  in  AW  register to mark pending.
REQ-015 BUSY_CNT  out  AW+1  number of registers currently marked pending.

Function
REQ-016 Register 0 SHALL read as 0 at all times; writes and pending marks to address 0 SHALL be ignored.
REQ-017 Write: WE3=1 and A3!=0 -> Registers[A3] <= WD3 at the rising edge.
REQ-018 Read: RDn = Registers[An], combinational, zero-latency.
REQ-019 Bypass (BYPASS=1): WE3=1, A3==An, A3!=0 -> RDn = WD3 in the same cycle.
REQ-020 Bypass (BYPASS=0): RDn SHALL return the pre-write value until the edge.
REQ-021 Each register SHALL have one busy bit; busy[0] SHALL be constant 0.
REQ-022 Busy update per edge: the bit is set by SET_EN at SET_ADDR and cleared by WE3 at A3.
REQ-023 Busy, simultaneous set and clear on the same address: set SHALL win, so the bit is 1 after the edge.
REQ-024 Set of an already-busy register SHALL leave it busy; BUSY_CNT SHALL not double-count it.
REQ-025 WE3 to a non-busy register SHALL write data and leave busy at 0.
REQ-026 BUSYn = busy[An], except when BYPASS=1 and a same-cycle write matches An (An!=0), in which case BUSYn = 0.
REQ-027 BUSY_CNT SHALL equal the popcount of the busy bits registered at the last edge; range 0..NREGS-1.
REQ-028 BUSY_CNT SHALL be maintained incrementally: +1, -1, 0 or net per edge; it SHALL never wrap.
REQ-029 When rst=1, RD1, RD2, BUSY1 and BUSY2 SHALL read 0 combinationally, regardless of bypass.

Reset
REQ-030 rst=1 at an edge SHALL clear all registers, all busy bits and BUSY_CNT to 0 in that single edge.
REQ-031 rst SHALL take priority over WE3 and SET_EN in the same cycle; both SHALL be discarded.
REQ-032 In the first cycle after rst deasserts, all reads SHALL return 0, and BUSYn and BUSY_CNT SHALL be 0.
REQ-033 Reset asserted with pending marks outstanding SHALL clear all of them; no late clear SHALL corrupt BUSY_CNT.

Verification
REQ-034 Basic write/read: write x5=0xDEADBEEF, next cycle A1=5 -> RD1=0xDEADBEEF; write x0=0x1234, then A2=0 -> RD2=0.
REQ-035 Bypass: BYPASS=1, same cycle WE3=1, A3=7, WD3=0xA5A5A5A5, A1=7 -> RD1=0xA5A5A5A5 and BUSY1=0. BYPASS=0, same stimulus -> RD1 = old x7.
REQ-036 Scoreboard: SET x3, next cycle BUSY1=1 (A1=3) and BUSY_CNT=1. Write x3 -> BUSY_CNT=0 next cycle.
REQ-037 Collision: x4 busy; same cycle SET_EN=1, SET_ADDR=4, WE3=1, A3=4 -> after edge busy[4]=1, BUSY_CNT unchanged at 1, x4 updated.
REQ-038 Saturation: set all registers 1..NREGS-1 -> BUSY_CNT=NREGS-1; SET x0 -> unchanged; re-set x9 -> unchanged.
REQ-039 Reset mid-operation: 3 busy and x2=0x55; rst=1 alongside WE3 to x2 and SET x6 -> after edge all registers 0, BUSY_CNT=0, reads 0.
